// File: rtl/counter_syn_evcnt_if.sv
// Read-port bundle for counter_syn_evcnt: request/channel/ack from the consumer,
// ready/valid/data/overflow back from the counter block.
interface counter_syn_evcnt_if #(
    parameter int COUNTER_NUM = 4,
    parameter int CNT_W       = 16
);
    localparam int CH_W = (COUNTER_NUM > 1) ? $clog2(COUNTER_NUM) : 1;

    logic            i_rd_req;
    logic [CH_W-1:0] i_rd_ch;
    logic            i_rd_ack;
    logic            o_rd_rdy;
    logic            o_rd_vld;
    logic [CNT_W-1:0] o_rd_data;
    logic            o_rd_ovf;

    modport master (
        output i_rd_req, i_rd_ch, i_rd_ack,
        input  o_rd_rdy, o_rd_vld, o_rd_data, o_rd_ovf
    );

    modport slave (
        input  i_rd_req, i_rd_ch, i_rd_ack,
        output o_rd_rdy, o_rd_vld, o_rd_data, o_rd_ovf
    );
endinterface

// File: rtl/counter_syn_evcnt.sv
// Per-channel saturating edge counters with a read-and-clear req/ack port.
// Latency: edge -> count 1 cycle; read accept -> o_rd_vld 1 cycle, ack -> rdy 1 cycle.
// Backpressure: result held in HOLD until i_rd_ack; requests ignored meanwhile, counting continues.
module counter_syn_evcnt #(
    parameter int COUNTER_NUM = 4,
    parameter int CNT_W       = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [COUNTER_NUM-1:0]   i_syn_din,
    input  logic [2*COUNTER_NUM-1:0] i_edge_mode,
    input  logic                     i_clr,
    counter_syn_evcnt_if.slave       rd
);
    localparam int CH_W = (COUNTER_NUM > 1) ? $clog2(COUNTER_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [COUNTER_NUM-1:0] prev_q;
    logic                   primed_q;
    logic [CNT_W-1:0]       cnt_q   [COUNTER_NUM];
    logic [CNT_W-1:0]       cnt_inc [COUNTER_NUM];
    logic [COUNTER_NUM-1:0] ovf_q, ovf_inc, edge_hit;
    logic [CNT_W-1:0]       rd_data_q, cap_data;
    logic                   rd_ovf_q, cap_ovf;
    logic                   accept;

    // Count this cycle's qualified edge; a hit on a saturated counter only raises ovf.
    always_comb begin
        for (int i = 0; i < COUNTER_NUM; i++) begin
            edge_hit[i] = primed_q &&
                          ((i_edge_mode[2*i]   &&  i_syn_din[i] && !prev_q[i]) ||
                           (i_edge_mode[2*i+1] && !i_syn_din[i] &&  prev_q[i]));
            cnt_inc[i] = cnt_q[i];
            ovf_inc[i] = ovf_q[i];
            if (edge_hit[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_inc[i] = 1'b1;
                end else begin
                    cnt_inc[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Out-of-range channels match nothing and capture 0/0.
    always_comb begin
        cap_data = '0;
        cap_ovf  = 1'b0;
        for (int i = 0; i < COUNTER_NUM; i++) begin
            if (rd.i_rd_ch == CH_W'(i)) begin
                cap_data = cnt_inc[i];
                cap_ovf  = ovf_inc[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd.i_rd_req) begin
                    accept  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rd.i_rd_ack) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            primed_q  <= 1'b0;
            ovf_q     <= '0;
            rd_data_q <= '0;
            rd_ovf_q  <= 1'b0;
            for (int i = 0; i < COUNTER_NUM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            prev_q   <= i_syn_din;
            primed_q <= 1'b1;
            if (accept) begin
                rd_data_q <= cap_data;
                rd_ovf_q  <= cap_ovf;
            end
            for (int i = 0; i < COUNTER_NUM; i++) begin
                if (i_clr || (accept && (rd.i_rd_ch == CH_W'(i)))) begin
                    cnt_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end else begin
                    cnt_q[i] <= cnt_inc[i];
                    ovf_q[i] <= ovf_inc[i];
                end
            end
        end
    end

    assign rd.o_rd_rdy  = (state_q == IDLE);
    assign rd.o_rd_vld  = (state_q == HOLD);
    assign rd.o_rd_data = rd_data_q;
    assign rd.o_rd_ovf  = rd_ovf_q;
endmodule
